button_debounce: RTL and testbench

- Front-end conditioning stage for one raw board push-button (BUT1/BUT2) before it reaches the LED logic in top.
- Synchronises the asynchronous pin and rejects bounce with a settle-counter state machine.
- Outputs a clean registered level plus one-cycle press, release and long-press strobes.
- top instantiates one per button.

---
 rtl/btn_pkg.sv | 15 +
 rtl/sync_2ff.sv | 23 ++
 rtl/button_debounce.sv | 122 ++++++++++++
 tb/tb_button_debounce.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared button-conditioning states and clock-derived defaults
package btn_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_SETTLE_P = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_SETTLE_R = 2'd3
    } btn_state_t;

    localparam int CLK_HZ              = 12_000_000;
    localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;
    localparam int DEF_LONG_CYCLES     = CLK_HZ;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for asynchronous board inputs
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - push-button synchroniser, debouncer and press/release/long strobes
module button_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic BUT,
    output logic PRESSED,
    output logic PRESS,
    output logic RELEASE,
    output logic LONG
);

    localparam bit LONG_EN = (LONG_CYCLES > 0);
    localparam int SW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW      = LONG_EN ? $clog2(LONG_CYCLES + 1) : 1;
    localparam logic [SW-1:0] DB_MAX   = SW'(DEBOUNCE_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX = LONG_EN ? HW'(LONG_CYCLES) : '0;

    logic but_q;
    logic b_s;

    btn_state_t    state, state_n;
    logic [SW-1:0] settle, settle_n;
    logic [HW-1:0] hold, hold_n;
    logic          pressed_n, press_n, release_n, long_n;

    // Sync flops reset to the idle pin level so reset exit never looks like a press.
    sync_2ff #(.RESET_VAL(ACTIVE_LOW)) u_sync (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (BUT),
        .q     (but_q)
    );

    assign b_s = ACTIVE_LOW ? ~but_q : but_q;

    always_comb begin
        state_n   = state;
        settle_n  = settle;
        hold_n    = hold;
        pressed_n = PRESSED;
        press_n   = 1'b0;
        release_n = 1'b0;
        long_n    = 1'b0;
        case (state)
            ST_RELEASED: begin
                if (b_s) begin
                    state_n  = ST_SETTLE_P;
                    settle_n = SW'(1);
                end
            end
            ST_SETTLE_P: begin
                if (!b_s) begin
                    state_n  = ST_RELEASED;
                    settle_n = '0;
                end else if (settle == DB_MAX) begin
                    state_n   = ST_PRESSED;
                    settle_n  = '0;
                    hold_n    = '0;
                    pressed_n = 1'b1;
                    press_n   = 1'b1;
                end else begin
                    settle_n = settle + SW'(1);
                end
            end
            ST_PRESSED: begin
                // Hold counter saturates, so LONG fires once per accepted press.
                if (LONG_EN && (hold < HOLD_MAX)) begin
                    hold_n = hold + HW'(1);
                    long_n = (hold_n == HOLD_MAX);
                end
                if (!b_s) begin
                    state_n  = ST_SETTLE_R;
                    settle_n = SW'(1);
                end
            end
            ST_SETTLE_R: begin
                if (b_s) begin
                    state_n  = ST_PRESSED;
                    settle_n = '0;
                end else if (settle == DB_MAX) begin
                    state_n   = ST_RELEASED;
                    settle_n  = '0;
                    pressed_n = 1'b0;
                    release_n = 1'b1;
                end else begin
                    settle_n = settle + SW'(1);
                end
            end
            default: begin
                state_n  = ST_RELEASED;
                settle_n = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= ST_RELEASED;
            settle  <= '0;
            hold    <= '0;
            PRESSED <= 1'b0;
            PRESS   <= 1'b0;
            RELEASE <= 1'b0;
            LONG    <= 1'b0;
        end else begin
            state   <= state_n;
            settle  <= settle_n;
            hold    <= hold_n;
            PRESSED <= pressed_n;
            PRESS   <= press_n;
            RELEASE <= release_n;
            LONG    <= long_n;
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - directed self-checking bench for button_debounce
module tb_button_debounce;

    logic CLK = 1'b0;
    logic RST_N;
    logic BUT;
    logic PRESSED, PRESS, RELEASE, LONG;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int press_cnt = 0, release_cnt = 0, long_cnt = 0;
    int press_cyc = -1, release_cyc = -1, long_cyc = -1;
    int bad_pr = 0, bad_lp = 0, bad_lnp = 0;

    button_debounce #(
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (20),
        .ACTIVE_LOW      (1'b0)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .BUT     (BUT),
        .PRESSED (PRESSED),
        .PRESS   (PRESS),
        .RELEASE (RELEASE),
        .LONG    (LONG)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Strobe log, sampled mid-cycle; cyc equals the index of the edge that set the outputs.
    always @(negedge CLK) begin
        if (RST_N) begin
            if (PRESS)   begin press_cnt++;   press_cyc   = cyc; end
            if (RELEASE) begin release_cnt++; release_cyc = cyc; end
            if (LONG)    begin long_cnt++;    long_cyc    = cyc; end
            if (PRESS && RELEASE) bad_pr++;
            if (LONG && PRESS)    bad_lp++;
            if (LONG && !PRESSED) bad_lnp++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    int t0, t1, pb, rb, lb;

    initial begin
        RST_N = 1'b0;
        BUT   = 1'b0;
        wait_cycles(3);
        check("rst_outputs", {28'd0, PRESSED, PRESS, RELEASE, LONG}, 32'd0);
        RST_N = 1'b1;
        wait_cycles(5);
        check("idle_pressed", PRESSED, 0);
        check("idle_strobes", press_cnt + release_cnt + long_cnt, 0);

        // Clean press held 40 cycles, then clean release.
        pb = press_cnt; rb = release_cnt; lb = long_cnt;
        t0 = cyc; BUT = 1'b1;
        wait_cycles(40);
        check("clean_press_cnt", press_cnt - pb, 1);
        check("clean_press_lat", press_cyc - t0, 7);
        check("clean_pressed", PRESSED, 1);
        check("clean_no_release", release_cnt - rb, 0);
        check("long_cnt", long_cnt - lb, 1);
        check("long_after_press", long_cyc - press_cyc, 20);
        t1 = cyc; BUT = 1'b0;
        wait_cycles(15);
        check("release_cnt", release_cnt - rb, 1);
        check("release_lat", release_cyc - t1, 7);
        check("released_level", PRESSED, 0);

        // Bounce: 2-cycle pulses never reach 4 stable samples.
        pb = press_cnt; rb = release_cnt;
        for (int i = 0; i < 10; i++) begin
            BUT = ~BUT;
            wait_cycles(2);
        end
        BUT = 1'b0;
        wait_cycles(10);
        check("bounce_pressed", PRESSED, 0);
        check("bounce_press", press_cnt - pb, 0);
        check("bounce_release", release_cnt - rb, 0);

        // Release glitch of 2 cycles: LONG slips by the two frozen cycles to t0+29.
        pb = press_cnt; rb = release_cnt; lb = long_cnt;
        t0 = cyc; BUT = 1'b1;
        wait_cycles(10);
        BUT = 1'b0;
        wait_cycles(2);
        BUT = 1'b1;
        wait_cycles(30);
        check("glitch_press", press_cnt - pb, 1);
        check("glitch_press_lat", press_cyc - t0, 7);
        check("glitch_no_release", release_cnt - rb, 0);
        check("glitch_pressed", PRESSED, 1);
        check("glitch_long_cnt", long_cnt - lb, 1);
        check("glitch_long_time", long_cyc - t0, 29);
        t1 = cyc; BUT = 1'b0;
        wait_cycles(12);
        check("glitch_release_lat", release_cyc - t1, 7);

        // Reset mid-settle (settle counter = 2 after edge t0+4).
        pb = press_cnt; rb = release_cnt; lb = long_cnt;
        t0 = cyc; BUT = 1'b1;
        wait_cycles(4);
        RST_N = 1'b0;
        #1;
        check("rst_settle_pressed", PRESSED, 0);
        BUT = 1'b0;
        wait_cycles(2);
        RST_N = 1'b1;
        wait_cycles(10);
        check("rst_settle_strobes", (press_cnt - pb) + (release_cnt - rb) + (long_cnt - lb), 0);

        // Reset while pressed: level drops before the next clock edge.
        BUT = 1'b1;
        wait_cycles(10);
        check("pre_rst_pressed", PRESSED, 1);
        pb = press_cnt; rb = release_cnt; lb = long_cnt;
        RST_N = 1'b0;
        #1;
        check("rst_async_drop", {28'd0, PRESSED, PRESS, RELEASE, LONG}, 32'd0);
        BUT = 1'b0;
        wait_cycles(2);
        RST_N = 1'b1;
        wait_cycles(10);
        check("rst_exit_strobes", (press_cnt - pb) + (release_cnt - rb) + (long_cnt - lb), 0);
        check("rst_exit_pressed", PRESSED, 0);

        // Slow toggling: each strobe lags its pin edge by 7 cycles.
        pb = press_cnt; rb = release_cnt;
        for (int k = 0; k < 31; k++) begin
            BUT = ~BUT;
            t0  = cyc;
            wait_cycles(314);
            if (BUT) check("tog_press_lat", press_cyc - t0, 7);
            else     check("tog_release_lat", release_cyc - t0, 7);
        end
        check("tog_press_cnt", press_cnt - pb, 16);
        check("tog_release_cnt", release_cnt - rb, 15);

        check("never_press_and_release", bad_pr, 0);
        check("never_long_with_press", bad_lp, 0);
        check("never_long_unpressed", bad_lnp, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
